// File: rtl/imm_encode_pkg.sv
// rtl/imm_encode_pkg.sv - shared immediate format enum, RV32 field positions, range helper
package imm_encode_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2,
    IMM_J = 2'd3
  } imm_src_t;

  // Highest immediate bit any format places into the instruction word is imm[20].
  localparam int IMM_KEEP_W = 21;

  localparam int I_IMM_LSB  = 20;
  localparam int S_HI_LSB   = 25;
  localparam int S_LO_LSB   = 7;
  localparam int B_SIGN     = 31;
  localparam int B_HI_LSB   = 25;
  localparam int B_LO_LSB   = 8;
  localparam int B_B11      = 7;
  localparam int J_SIGN     = 31;
  localparam int J_LO_LSB   = 21;
  localparam int J_B11      = 20;
  localparam int J_MID_LSB  = 12;

  function automatic logic imm_fits(input imm_src_t src, input logic [31:0] imm);
    logic fits;
    fits = 1'b0;
    case (src)
      IMM_I, IMM_S: fits = (&imm[31:11]) || !(|imm[31:11]);
      IMM_B:        fits = !imm[0] && ((&imm[31:12]) || !(|imm[31:12]));
      IMM_J:        fits = !imm[0] && ((&imm[31:20]) || !(|imm[31:20]));
      default:      fits = 1'b0;
    endcase
    return fits;
  endfunction

endpackage

// File: rtl/imm_field_pack.sv
// rtl/imm_field_pack.sv - combinational scatter of immediate bits into RV32 instruction fields
module imm_field_pack
  import imm_encode_pkg::*;
(
  input  imm_src_t                imm_src,
  input  logic [IMM_KEEP_W-1:0]   imm,
  input  logic [31:0]             base,
  output logic [31:0]             instr
);

  always_comb begin
    instr = base;
    case (imm_src)
      IMM_I: instr[31:I_IMM_LSB] = imm[11:0];
      IMM_S: begin
        instr[31:S_HI_LSB]          = imm[11:5];
        instr[S_LO_LSB+4:S_LO_LSB]  = imm[4:0];
      end
      IMM_B: begin
        instr[B_SIGN]               = imm[12];
        instr[B_HI_LSB+5:B_HI_LSB]  = imm[10:5];
        instr[B_LO_LSB+3:B_LO_LSB]  = imm[4:1];
        instr[B_B11]                = imm[11];
      end
      IMM_J: begin
        instr[J_SIGN]                = imm[20];
        instr[J_LO_LSB+9:J_LO_LSB]   = imm[10:1];
        instr[J_B11]                 = imm[11];
        instr[J_MID_LSB+7:J_MID_LSB] = imm[19:12];
      end
      default: instr = base;
    endcase
  end

endmodule

// File: rtl/imm_encode.sv
// rtl/imm_encode.sv - two-stage immediate encoder; IMM_ENCODE_RANGE_CHECK_EN enables range check and error count
module imm_encode
  import imm_encode_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_imm_src,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_range_err,
  output logic [7:0]  err_cnt
);

  logic                  s1_valid;
  imm_src_t              s1_src;
  logic [IMM_KEEP_W-1:0] s1_imm;
  logic [31:0]           s1_base;
  logic                  s2_load;
  logic                  s1_load;
  logic [31:0]           packed_word;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign s1_load  = in_ready && in_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_src   <= IMM_I;
      s1_imm   <= '0;
      s1_base  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_src  <= imm_src_t'(in_imm_src);
        s1_imm  <= in_imm[IMM_KEEP_W-1:0];
        s1_base <= in_base;
      end
    end
  end

  imm_field_pack u_pack (
    .imm_src (s1_src),
    .imm     (s1_imm),
    .base    (s1_base),
    .instr   (packed_word)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_instr <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) out_instr <= packed_word;
    end
  end

`ifdef IMM_ENCODE_RANGE_CHECK_EN
  logic s1_err;

  // Error flag travels alongside its word so it lines up with out_instr.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_err        <= 1'b0;
      out_range_err <= 1'b0;
      err_cnt       <= '0;
    end else begin
      if (s1_load) s1_err <= !imm_fits(imm_src_t'(in_imm_src), in_imm);
      if (s2_load && s1_valid) out_range_err <= s1_err;
      if (out_valid && out_ready && out_range_err && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^{in_imm[31:IMM_KEEP_W], s1_load};
  assign out_range_err = 1'b0;
  assign err_cnt       = '0;
`endif

endmodule

// File: doc/imm_encode.md
# imm_encode

Pipelined immediate encoder: the inverse of the core's immediate extender. Accepts a 32-bit signed immediate, an immediate format selector and a base instruction word, range-checks the immediate for that format, and scatters its bits into the format-specific instruction fields. It sits between the debug/patch unit and instruction memory write port, producing encoded branch/jump/load/store/ALU-immediate words for in-system firmware patching and self-test generation.

## Interface
- No parameters; all widths fixed by RV32I.
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  encoder can accept input this cycle
- in_imm_src  in  2  format: 0=I, 1=S, 2=B, 3=J
- in_imm  in  32  signed immediate (byte offset for B/J)
- in_base  in  32  base instruction; immediate field bits are overwritten, all others pass through
- out_valid  out  1  encoded word valid
- out_ready  in  1  downstream accepts this cycle
- out_instr  out  32  encoded instruction
- out_range_err  out  1  immediate did not fit the selected format
- err_cnt  out  8  saturating count of range errors delivered

## Operation
- Two-stage pipeline. S1 registers imm_src, imm, base and range-check result; S2 registers merged word and error flag.
- Range rules: I/S: in_imm[31:11] all equal. B: in_imm[0]==0 and in_imm[31:12] all equal. J: in_imm[0]==0 and in_imm[31:20] all equal.
- Field placement: I: [31:20]=imm[11:0]. S: [31:25]=imm[11:5], [11:7]=imm[4:0]. B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- On range error the word is still produced from the truncated bits above; out_range_err=1 accompanies it.
- err_cnt increments on each output handshake (out_valid && out_ready) with out_range_err=1; saturates at 255.

## Timing
- Reset: out_valid=0, out_instr=0, out_range_err=0, err_cnt=0, both stages empty, in_ready=1.
- Latency: input handshake in cycle N -> out_valid in cycle N+2 if unstalled.
- Throughput: one word per cycle when out_ready=1.
- Handshake: transfer when valid && ready. out_valid/out_instr/out_range_err hold stable while out_valid && !out_ready.
- Stage advance: S2 loads when S2 empty or out_ready=1; S1 loads when S1 empty or S1 moves to S2. in_ready = !s1_valid || s2 loads; combinational, no dependency on in_valid.
- Full: both stages held with out_ready=0 -> in_ready=0; no word dropped or duplicated.
- Simultaneous input and output handshake in a full pipeline: both occur, occupancy unchanged.
- Reset mid-operation: in-flight words discarded, err_cnt cleared.

## Configuration
- IMM_ENCODE_RANGE_CHECK_EN defined: range rules, out_range_err and err_cnt as above.
- Not defined: no check logic; out_range_err tied 0, err_cnt tied 0; encoding, latency and handshake unchanged.

## Structure
- Shared package: imm_src_t enum (IMM_I, IMM_S, IMM_B, IMM_J = 0..3) shared with the immediate extender and decoder; RV32 field bit-position constants.
- Sub-module imm_field_pack: combinational (imm_src, imm, base) -> merged word; pipeline, handshake, range check and counter stay in imm_encode.

## Test plan
- I: imm=0x00000001, base=0x00000013 -> out_instr=0x00100013, err=0, two cycles after input handshake.
- S: imm=0x000007FA, base=0x00002023 -> 0x7E002D23; B: imm=0x00000008, base=0x00000063 -> 0x00000463; J: imm=0x000007E6, base=0x0000006F -> 0x7E60006F.
- Range: I imm=0x00000800, base=0x00000013 -> 0x80000013 with err=1; B imm=0x00000005 -> err=1; after both accepted err_cnt=2; 300 errors -> err_cnt=255.
- Backpressure: 4 back-to-back inputs, out_ready=0 for 5 cycles -> in_ready falls after 2 accepted, outputs stable, all 4 words delivered in order once out_ready=1.
- Streaming: in_valid=out_ready=1 for 16 cycles -> 16 outputs, one per cycle, from cycle 2.
- Reset with 2 words in flight -> out_valid=0 next cycle, err_cnt=0, in_ready=1; with macro undefined, range-test vectors give err=0 and err_cnt=0.
